// File: rtl/aes_128_iter_ctrl_if.sv
// Request/response handshake bundle for the iterative AES-128 controller.
// The requester drives plaintext/key and accepts ciphertext (master); the
// controller consumes requests and produces results (slave).
interface aes_128_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_plaintext;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ciphertext;

  modport master (
    output in_valid, in_plaintext, in_key, out_ready,
    input  in_ready, out_valid, out_ciphertext
  );

  modport slave (
    input  in_valid, in_plaintext, in_key, out_ready,
    output in_ready, out_valid, out_ciphertext
  );
endinterface

// File: rtl/aes_128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round datapath reused over ten cycles,
// key schedule expanded combinationally from a registered copy of the key.

package aes_128_pkg;
  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, which maps 0 to 0) plus the
  // affine transform; avoids a hand-entered 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

// Full key schedule: round key i occupies round_keys_o[1407-128*i -: 128].
module key_expansion_128
  import aes_128_pkg::*;
(
  input  logic [127:0]  key_i,
  output logic [1407:0] round_keys_o
);
  // Expand 44 schedule words from the cipher key.
  always_comb begin
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    round_keys_o = '0;
    rcon         = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key_i[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) round_keys_o[1407-32*i -: 32] = w[i];
  end
endmodule

// Initial AddRoundKey.
module add_round_key_128 (
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  output logic [127:0] state_o
);
  assign state_o = state_i ^ round_key_i;
endmodule

// One cipher round; MixColumns is bypassed on the final round.
// Byte n of a block sits at bits [127-8n -: 8] and maps to row n%4, column n/4.
module aes_round_logic
  import aes_128_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         is_final_i,
  output logic [127:0] state_o
);
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar n = 0; n < 16; n++) begin : g_sub
    assign sb[n] = sbox(state_i[127-8*n -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[r+4*c] = sb[r + 4*((c + r) % 4)];
    end
    assign mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  for (genvar n = 0; n < 16; n++) begin : g_ark
    assign state_o[127-8*n -: 8] = (is_final_i ? sr[n] : mc[n]) ^ round_key_i[127-8*n -: 8];
  end
endmodule

module aes_128_iter_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  aes_128_iter_ctrl_if.slave    bus,
  output logic                  busy,
  output logic [3:0]            round_idx
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e       fsm_q;
  logic [127:0] key_q;
  logic [127:0] state_q;
  logic [3:0]   round_cnt_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  logic [1407:0]        round_keys_flat;
  logic [0:10][127:0]   round_keys;
  logic [127:0]         init_d;
  logic [127:0]         round_d;

  key_expansion_128 u_key_exp (
    .key_i        (key_q),
    .round_keys_o (round_keys_flat)
  );

  // Same layout as the flat vector: element 0 holds bits 1407:1280.
  assign round_keys = round_keys_flat;

  // Round key 0 is the cipher key itself, so the initial add uses in_key directly.
  add_round_key_128 u_ark0 (
    .state_i     (bus.in_plaintext),
    .round_key_i (bus.in_key),
    .state_o     (init_d)
  );

  aes_round_logic u_round (
    .state_i     (state_q),
    .round_key_i (round_keys[round_cnt_q]),
    .is_final_i  (round_cnt_q == 4'd10),
    .state_o     (round_d)
  );

  // Controller FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      // NOTE: the data registers are reset too, since out_ciphertext must read zero out of reset.
      key_q       <= '0;
      state_q     <= '0;
      round_cnt_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (fsm_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            key_q       <= bus.in_key;
            state_q     <= init_d;
            round_cnt_q <= 4'd1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            fsm_q       <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_d;
          if (round_cnt_q == 4'd10) begin
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            round_cnt_q <= round_cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            round_cnt_q <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_ciphertext = state_q;
  assign busy               = busy_q;
  assign round_idx          = round_cnt_q;
endmodule

// File: tb/tb_aes_128_iter_ctrl.sv
// Scoreboard bench for the iterative AES-128 controller: expected ciphertexts
// come from a reference AES model with a generated S-box, plus known answers.
module tb_aes_128_iter_ctrl;
  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [3:0] round_idx;

  aes_128_iter_ctrl_if bus ();

  aes_128_iter_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    int           acc_edge;
  } exp_t;

  exp_t     exp_q [$];
  int       n_checks  = 0;
  int       n_fails   = 0;
  int       cyc       = 0;
  int       n_accept  = 0;
  int       n_deliver = 0;
  int       n_discard = 0;
  int       last_acc  = 0;
  int       prev_acc  = 0;
  int       rdy_mode  = 0;
  bit [7:0] sbox_t [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model ------------------------------------------------------
  function automatic bit [7:0] xt(input bit [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box generated by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    bit [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    bit [31:0]    w [44];
    bit [7:0]     s [4][4];
    bit [7:0]     t [4][4];
    bit [31:0]    tmp;
    bit [7:0]     rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[0][c] = xt(t[0][c]) ^ xt(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ xt(t[1][c]) ^ xt(t[2][c]) ^ t[2][c] ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ xt(t[2][c]) ^ xt(t[3][c]) ^ t[3][c];
          s[3][c] = xt(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ xt(t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // Edge counter used to time acceptances and results.
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer readiness: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  initial begin
    exp_t e;
    bit   ov_prev;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
      end else begin
        check("busy_vs_in_ready", 128'(busy), 128'(!bus.in_ready));
        if (bus.in_valid && bus.in_ready) begin
          e.ct       = aes_ref(bus.in_plaintext, bus.in_key);
          e.acc_edge = cyc + 1;
          exp_q.push_back(e);
          n_accept++;
          prev_acc = last_acc;
          last_acc = cyc + 1;
        end
        if (bus.out_valid) begin
          check("no_bypass", 128'(bus.in_ready), 128'(0));
          if (exp_q.size() == 0) begin
            check("spurious_out", 128'(1), 128'(0));
          end else begin
            check("ciphertext", bus.out_ciphertext, exp_q[0].ct);
            if (!ov_prev) check("latency", 128'(cyc - exp_q[0].acc_edge), 128'(10));
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              n_deliver++;
            end
          end
        end
        ov_prev = bus.out_valid;
      end
    end
  end

  // Bounded helpers ------------------------------------------------------
  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    bus.in_plaintext = pt;
    bus.in_key       = key;
    bus.in_valid     = 1'b1;
    wait_accept();
    bus.in_valid     = 1'b0;
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    if (!ok) check("out_valid_timeout", 128'(0), 128'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached before test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
    $fatal(1, "watchdog");
  end

  // Directed sequence followed by random regression.
  initial begin
    int d0;
    int a0;
    bit ok;
    build_sbox();
    bus.in_valid     = 1'b0;
    bus.in_plaintext = '0;
    bus.in_key       = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready",  128'(bus.in_ready),  128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_busy",      128'(busy),          128'(0));
    check("rst_round_idx", 128'(round_idx),     128'(0));
    check("rst_ct",        bus.out_ciphertext,  128'(0));
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector 1, consumer always ready.
    send(V1_PT, V1_KEY);
    wait_out();
    check("v1_ct", bus.out_ciphertext, V1_CT);
    @(negedge clk);
    check("v1_valid_pulse", 128'(bus.out_valid), 128'(0));
    drain();

    // Vector 2 with a 7-cycle stall.
    rdy_mode = 1;
    @(posedge clk);
    #1;
    d0 = n_deliver;
    send(V2_PT, V2_KEY);
    wait_out();
    for (int i = 0; i < 7; i++) begin
      check("v2_stall_in_ready",  128'(bus.in_ready),  128'(0));
      check("v2_stall_out_valid", 128'(bus.out_valid), 128'(1));
      check("v2_stall_ct",        bus.out_ciphertext,  V2_CT);
      @(negedge clk);
    end
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    check("v2_single_xfer", 128'(n_deliver - d0), 128'(1));
    drain();

    // Back-to-back with in_valid held high.
    @(posedge clk);
    #1;
    a0 = n_accept;
    bus.in_plaintext = V1_PT;
    bus.in_key       = V1_KEY;
    bus.in_valid     = 1'b1;
    wait_accept();
    bus.in_plaintext = V2_PT;
    bus.in_key       = V2_KEY;
    wait_accept();
    bus.in_valid     = 1'b0;
    check("b2b_gap", 128'(last_acc - prev_acc), 128'(12));
    check("b2b_accepts", 128'(n_accept - a0), 128'(2));
    drain();

    // Inputs change while rounds are in flight.
    @(posedge clk);
    #1;
    send(V1_PT, V1_KEY);
    for (int i = 0; i < 6; i++) begin
      bus.in_plaintext = rand128();
      bus.in_key       = rand128();
      bus.in_valid     = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_out();
    check("midchg_ct", bus.out_ciphertext, V1_CT);
    drain();

    // Asynchronous reset in the middle of round 5.
    @(posedge clk);
    #1;
    send(V1_PT, V1_KEY);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (round_idx == 4'd5) ok = 1'b1;
    end
    if (!ok) check("round5_timeout", 128'(0), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  128'(bus.in_ready),  128'(1));
    check("mid_rst_busy",      128'(busy),          128'(0));
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_round_idx", 128'(round_idx),     128'(0));
    check("mid_rst_ct",        bus.out_ciphertext,  128'(0));
    n_discard += exp_q.size();
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_no_stale", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;
    send(V2_PT, V2_KEY);
    wait_out();
    check("post_rst_ct", bus.out_ciphertext, V2_CT);
    drain();

    // Random regression with random backpressure.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    for (int n = 0; n < 1000; n++) begin
      send(rand128(), rand128());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("accept_vs_deliver", 128'(n_accept - n_discard), 128'(n_deliver));
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/aes_128_iter_ctrl.md
# aes_128_iter_ctrl

Iterative AES-128 encryption controller that sequences a single `aes_round_logic` instance over ten clock cycles instead of unrolling ten round instances. It accepts one plaintext/key pair per request over a valid/ready handshake and holds the block state in a register. It selects the round key for the current round from a `key_expansion_128` instance driven by a registered copy of the key. It returns the ciphertext over a second valid/ready handshake, trading throughput for roughly one tenth of the round-logic area.

## Interface
- No parameters. The datapath is fixed at 128 bits, with 10 rounds and an 11×128-bit key schedule.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous active-high reset.
- `in_valid`  input  1  request carries valid `in_plaintext` and `in_key`.
- `in_ready`  output  1  controller can accept a request; high only in IDLE.
- `in_plaintext`  input  128  plaintext block.
- `in_key`  input  128  cipher key, sampled with the plaintext.
- `out_valid`  output  1  `out_ciphertext` is valid.
- `out_ready`  input  1  consumer accepts the ciphertext.
- `out_ciphertext`  output  128  ciphertext, driven directly from the state register.
- `busy`  output  1  high in ROUND or DONE.
- `round_idx`  output  4  current round counter, 0–10, for debug.

## Operation
- **Submodules:** one `key_expansion_128` (input `key_reg`), one `add_round_key_128` (initial round), one `aes_round_logic`.
  - Round key i = `round_keys[1407-128*i -: 128]`.
  - Round key 0 = `round_keys[1407:1280]`.
- **Registers:** `key_reg[127:0]`, `state_reg[127:0]`, `round_cnt[3:0]`, FSM state.
- **FSM IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`: `key_reg` ← `in_key`; `state_reg` ← `in_plaintext ^ round key 0`; `round_cnt` ← 1; go to ROUND.
  - Round key 0 for this initial add is computed from `in_key` directly, so a second combinational path through the key expansion (or an equivalent slice of `in_key`) is used. Round key 0 equals the key itself, so `in_plaintext ^ in_key` is acceptable.
- **FSM ROUND:**
  - Each cycle: `state_reg` ← `aes_round_logic(state_reg, round key[round_cnt], is_final = (round_cnt==10))`.
  - If `round_cnt==10`, go to DONE; otherwise `round_cnt` ← `round_cnt`+1.
  - `in_valid` is ignored in this state.
- **FSM DONE:**
  - `out_valid`=1.
  - `state_reg`, `key_reg` and `round_cnt` (=10) are held stable until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE and set `round_cnt` ← 0.
- **Handshake rules:**
  - No bypass: `in_ready` is never high in the same cycle as `out_valid`.
  - `out_ciphertext` is only meaningful while `out_valid`=1.
  - The consumer may hold `out_ready` low indefinitely; the controller stalls in DONE with no data loss.
- **Reset (asynchronous, any state, including mid-round):** FSM ← IDLE; `round_cnt` ← 0; `state_reg` ← 0; `key_reg` ← 0. The in-flight block is discarded and no `out_valid` pulse is produced for it.
- **Reset values of outputs:** `in_ready`=1, `out_valid`=0, `busy`=0, `round_idx`=0, `out_ciphertext`=0.

## Timing
- Let the accepting edge be E0.
- Round edges are E1–E10; `out_valid` rises immediately after E10, i.e. 10 cycles after acceptance.
- The ciphertext transfers on the first edge with `out_ready`=1; if `out_ready` is already high, that is E11.
- `in_ready` is high in the cycle after E11, so the next block is accepted on E12 at the earliest.
- Minimum initiation interval is 12 cycles per block.
- The critical path is one round (SubBytes, ShiftRows, MixColumns, AddRoundKey) plus the key-expansion mux; no multicycle paths.
- `busy` = (FSM != IDLE), and is registered-state derived.

## Test plan
- **Vector 1:** key `000102030405060708090a0b0c0d0e0f`, plaintext `00112233445566778899aabbccddeeff`, `out_ready` tied high.
  - Required: `out_ciphertext` = `69c4e0d86a7b0430d8cdb78070b4c55a`.
  - Required: `out_valid` rises exactly 10 cycles after the accepting edge and lasts 1 cycle.
- **Vector 2 with backpressure:** key `2b7e151628aed2a6abf7158809cf4f3c`, plaintext `3243f6a8885a308d313198a2e0370734`, `out_ready` held low for 7 cycles.
  - Required: `out_ciphertext` = `3925841d02dc09fbdc118597196a0b32`, stable throughout the stall.
  - Required: a single transfer, and `in_ready`=0 throughout the stall.
- **Back-to-back:** `in_valid` held high with vector 1 then vector 2.
  - Required: both results come out in order, with acceptances 12 cycles apart.
  - Required: `in_valid` is ignored while busy, and no request is duplicated.
- **Input change mid-round:** change `in_plaintext` and `in_key` to random values during ROUND.
  - Required: the result is unaffected and equals the vector-1 ciphertext.
- **Reset mid-round:** assert `rst` at `round_idx`=5, asynchronously between edges.
  - Required: `in_ready`=1, `busy`=0 and `out_valid`=0 immediately; no stale output afterwards.
  - Required: the next request completes with the correct ciphertext.
- **Random regression:** 1000 random key/plaintext pairs with random `out_ready` backpressure.
  - Required: every output matches the `aes_128_full` golden model.
  - Required: the count of accepted requests equals the count of delivered outputs.
